// File: rtl/joy_pkg.sv
// Shared definitions for the joystick shift-register link: frame geometry,
// transmitter state encoding, edge-detector payload and the frame bit order.
package joy_pkg;

    localparam int unsigned JOY_WIDTH     = 12;
    localparam int unsigned JOY_FRAME_LEN = 24;
    localparam int unsigned JOY_CNT_W     = 5;
    localparam logic        JOY_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } joy_tx_state_t;

    // Synchronised level plus single-cycle rising-edge flag
    typedef struct packed {
        logic level;
        logic rise;
    } joy_edge_t;

    // Frame order, bit 0 first: [4] selects player (0 = joy1, 1 = joy2), [3:0] is the joy bit
    localparam logic [4:0] JOY_FRAME_ORDER [JOY_FRAME_LEN] = '{
        5'h08, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00,
        5'h18, 5'h16, 5'h15, 5'h14, 5'h13, 5'h12, 5'h11, 5'h10,
        5'h1A, 5'h1B, 5'h19, 5'h17,
        5'h0A, 5'h0B, 5'h09, 5'h07
    };

    // Assemble a serial frame from both player words using the order table
    function automatic logic [JOY_FRAME_LEN-1:0] joy_build_frame(
        input logic [JOY_WIDTH-1:0] j1,
        input logic [JOY_WIDTH-1:0] j2
    );
        logic [JOY_FRAME_LEN-1:0] frame;
        logic [4:0]               src;
        frame = '1;
        for (int i = 0; i < int'(JOY_FRAME_LEN); i++) begin
            src      = JOY_FRAME_ORDER[i];
            frame[i] = src[4] ? j2[src[3:0]] : j1[src[3:0]];
        end
        return frame;
    endfunction

endpackage

// File: rtl/joy_sync_edge.sv
// Synchroniser and rising-edge detector for one asynchronous reader line.
// Optional 3-sample majority filter enabled by JOY_TX_GLITCH_FILTER_EN.
module joy_sync_edge
    import joy_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      din,
    output joy_edge_t edge_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   prev_q;

    // Metastability chain; idles high so a released line looks inactive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

`ifdef JOY_TX_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    // Registered majority vote over three consecutive synchronised samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '1;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
            filt_q <= (sync_q[SYNC_STAGES-1] & hist_q[0]) |
                      (sync_q[SYNC_STAGES-1] & hist_q[1]) |
                      (hist_q[0] & hist_q[1]);
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    // Previous level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= lvl;
        end
    end

    assign edge_c.level = lvl;
    assign edge_c.rise  = lvl & ~prev_q;

endmodule

// File: rtl/joy_shift_tx.sv
// Joystick serial transmitter: presents two player words as a 24-bit frame
// shifted out on the reader's JOY_CLK after a JOY_LOAD strobe.
// Build option JOY_TX_GLITCH_FILTER_EN adds a majority filter on both lines.
module joy_shift_tx
    import joy_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk50mhz,
    input  logic                 reset_n,
    input  logic [JOY_WIDTH-1:0] joy1,
    input  logic [JOY_WIDTH-1:0] joy2,
    input  logic                 JOY_CLK,
    input  logic                 JOY_LOAD,
    output logic                 JOY_DATA,
    output logic                 frame_done,
    output logic                 busy
);

    logic [1:0]               rst_sync_q;
    logic                     rst_n;
    joy_edge_t                clk_ev;
    joy_edge_t                load_ev;
    logic                     load_low;
    logic                     shift_c;

    joy_tx_state_t            state_q, state_n;
    logic [JOY_FRAME_LEN-1:0] sr_q, sr_n;
    logic [JOY_CNT_W-1:0]     cnt_q, cnt_n;
    logic                     done_q, done_n;
    logic                     busy_q, busy_n;

    // Asynchronous assert, clock-synchronous release of the internal reset
    always_ff @(posedge clk50mhz or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    joy_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk    (clk50mhz),
        .rst_n  (rst_n),
        .din    (JOY_CLK),
        .edge_c (clk_ev)
    );

    joy_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .clk    (clk50mhz),
        .rst_n  (rst_n),
        .din    (JOY_LOAD),
        .edge_c (load_ev)
    );

    assign load_low = ~load_ev.level;
    // A shift request is a rising edge seen while the line is settled high
    assign shift_c  = clk_ev.rise & clk_ev.level;

    // State, shift register, counter and output flags
    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            sr_q    <= sr_n;
            cnt_q   <= cnt_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
        end
    end

    // Next-state, frame loading and shifting; LOAD low overrides everything
    always_comb begin
        state_n = state_q;
        sr_n    = sr_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_low) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                sr_n  = joy_build_frame(joy1, joy2);
                cnt_n = '0;
                if (load_ev.rise) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (load_low) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end else if (shift_c) begin
                    sr_n  = {JOY_IDLE_LEVEL, sr_q[JOY_FRAME_LEN-1:1]};
                    cnt_n = cnt_q + 1'b1;
                    if (cnt_q == JOY_CNT_W'(JOY_FRAME_LEN - 1)) begin
                        state_n = DRAIN;
                        done_n  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (load_low) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n == LOAD) || (state_n == SHIFT);
    end

    assign JOY_DATA   = sr_q[0];
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_joy_shift_tx.sv
// Directed bench for joy_shift_tx acting as the frame reader.
module tb_joy_shift_tx;

    localparam int SYNC = 2;
`ifdef JOY_TX_GLITCH_FILTER_EN
    localparam int LAT = SYNC + 3;
`else
    localparam int LAT = SYNC + 1;
`endif
    localparam int HALF = 8;

    logic        clk50mhz = 1'b0;
    logic        reset_n  = 1'b0;
    logic [11:0] joy1     = 12'hFFF;
    logic [11:0] joy2     = 12'hFFF;
    logic        JOY_CLK  = 1'b0;
    logic        JOY_LOAD = 1'b1;
    logic        JOY_DATA;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int passed = 0;
    int fd_cnt = 0;

    joy_shift_tx #(.SYNC_STAGES(SYNC)) dut (
        .clk50mhz   (clk50mhz),
        .reset_n    (reset_n),
        .joy1       (joy1),
        .joy2       (joy2),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_DATA   (JOY_DATA),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #10 clk50mhz = ~clk50mhz;

    // Advance n cycles, sampling on the falling edge and counting frame_done pulses
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk50mhz);
            fd_cnt += int'(frame_done);
        end
    endtask

    task automatic load_pulse();
        JOY_LOAD = 1'b0;
        cyc(HALF);
        JOY_LOAD = 1'b1;
        cyc(HALF);
    endtask

    // Reader behaviour: sample JOY_DATA, then raise JOY_CLK
    task automatic clock_bits(input int n, output logic [24:0] bits);
        bits = '1;
        for (int k = 0; k < n; k++) begin
            if (k < 25) bits[k] = JOY_DATA;
            JOY_CLK = 1'b1;
            cyc(HALF);
            JOY_CLK = 1'b0;
            cyc(HALF);
        end
    endtask

    task automatic run_frame(input logic [11:0] j1, input logic [11:0] j2, output logic [24:0] bits);
        joy1   = j1;
        joy2   = j2;
        fd_cnt = 0;
        load_pulse();
        clock_bits(25, bits);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(3);
        checks++; if (JOY_DATA !== 1'b1) $display("FAIL rst_data: got %b want 1", JOY_DATA); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL rst_done: got %b want 0", frame_done); else passed++;
        reset_n = 1'b1;
        cyc(5);
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
        checks++; if (JOY_DATA !== 1'b1) $display("FAIL idle_data: got %b want 1", JOY_DATA); else passed++;
    endtask

    task automatic test_frame();
        logic [24:0] b;
        run_frame(12'hFFE, 12'hFFF, b);
        checks++; if (b !== 25'h1FFFF7F) $display("FAIL frame_bits: got %h want 1ffff7f", b); else passed++;
        checks++; if (fd_cnt !== 1) $display("FAIL frame_done_cnt: got %0d want 1", fd_cnt); else passed++;
        checks++; if (JOY_DATA !== 1'b1) $display("FAIL frame_idle: got %b want 1", JOY_DATA); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL frame_busy: got %b want 0", busy); else passed++;
        clock_bits(3, b);
        checks++; if (b !== 25'h1FFFFFF) $display("FAIL drain_bits: got %h want 1ffffff", b); else passed++;
        checks++; if (fd_cnt !== 1) $display("FAIL drain_done_cnt: got %0d want 1", fd_cnt); else passed++;
    endtask

    task automatic test_bit_order();
        logic [11:0] j1v [5] = '{12'hFFF, 12'hDFF, 12'h000, 12'hFFF, 12'hF7F};
        logic [11:0] j2v [5] = '{12'hDFF, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF};
        logic [24:0] exp [5] = '{25'h1FBFFFF, 25'h1BFFFFF, 25'h10FFF00, 25'h1F000FF, 25'h17FFFFF};
        logic [24:0] b;
        for (int v = 0; v < 5; v++) begin
            run_frame(j1v[v], j2v[v], b);
            checks++; if (b !== exp[v]) $display("FAIL order_%0d: got %h want %h", v, b, exp[v]); else passed++;
            checks++; if (fd_cnt !== 1) $display("FAIL order_done_%0d: got %0d want 1", v, fd_cnt); else passed++;
        end
    endtask

    task automatic test_load_clk_coincide();
        logic [24:0] b;
        joy1     = 12'hEFF;
        joy2     = 12'hFFF;
        fd_cnt   = 0;
        JOY_LOAD = 1'b0;
        cyc(HALF);
        JOY_LOAD = 1'b1;
        JOY_CLK  = 1'b1;
        cyc(HALF);
        JOY_CLK  = 1'b0;
        cyc(HALF);
        checks++; if (JOY_DATA !== 1'b0) $display("FAIL coincide_bit0: got %b want 0", JOY_DATA); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL coincide_busy: got %b want 1", busy); else passed++;
        clock_bits(25, b);
        checks++; if (b !== 25'h1FFFFFE) $display("FAIL coincide_bits: got %h want 1fffffe", b); else passed++;
        checks++; if (fd_cnt !== 1) $display("FAIL coincide_done: got %0d want 1", fd_cnt); else passed++;
    endtask

    task automatic test_abort();
        logic [24:0] b;
        joy1   = 12'hFFE;
        joy2   = 12'hFFF;
        fd_cnt = 0;
        load_pulse();
        clock_bits(10, b);
        checks++; if (b !== 25'h1FFFF7F) $display("FAIL abort_partial: got %h want 1ffff7f", b); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", busy); else passed++;
        checks++; if (fd_cnt !== 0) $display("FAIL abort_early_done: got %0d want 0", fd_cnt); else passed++;
        joy1 = 12'hFFF;
        joy2 = 12'hFFE;
        load_pulse();
        clock_bits(25, b);
        checks++; if (b !== 25'h1FF7FFF) $display("FAIL abort_restart: got %h want 1ff7fff", b); else passed++;
        checks++; if (fd_cnt !== 1) $display("FAIL abort_done: got %0d want 1", fd_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [24:0] b;
        joy1   = 12'hFFF;
        joy2   = 12'hFF7;
        fd_cnt = 0;
        load_pulse();
        clock_bits(12, b);
        checks++; if (JOY_DATA !== 1'b0) $display("FAIL mid_bit12: got %b want 0", JOY_DATA); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else passed++;
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (JOY_DATA !== 1'b1) $display("FAIL async_data: got %b want 1", JOY_DATA); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL async_busy: got %b want 0", busy); else passed++;
        @(negedge clk50mhz);
        reset_n = 1'b1;
        cyc(5);
        run_frame(12'hFFE, 12'hFFF, b);
        checks++; if (b !== 25'h1FFFF7F) $display("FAIL post_rst_bits: got %h want 1ffff7f", b); else passed++;
        checks++; if (fd_cnt !== 1) $display("FAIL post_rst_done: got %0d want 1", fd_cnt); else passed++;
    endtask

    task automatic test_latency();
        int lat;
        joy1 = 12'hEFF;
        joy2 = 12'hFFF;
        load_pulse();
        checks++; if (JOY_DATA !== 1'b0) $display("FAIL lat_bit0: got %b want 0", JOY_DATA); else passed++;
        lat = 0;
        JOY_CLK = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk50mhz);
            if (lat == 0 && JOY_DATA !== 1'b0) lat = c;
        end
        JOY_CLK = 1'b0;
        cyc(HALF);
        checks++; if (lat !== LAT) $display("FAIL latency: got %0d cycles want %0d", lat, LAT); else passed++;
    endtask

`ifdef JOY_TX_GLITCH_FILTER_EN
    task automatic test_glitch();
        joy1 = 12'hEFF;
        joy2 = 12'hFFF;
        load_pulse();
        JOY_CLK = 1'b1;
        @(negedge clk50mhz);
        JOY_CLK = 1'b0;
        cyc(2 * HALF);
        checks++; if (JOY_DATA !== 1'b0) $display("FAIL glitch: got %b want 0", JOY_DATA); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_bit_order();
        test_load_clk_coincide();
        test_abort();
        test_reset_mid();
        test_latency();
`ifdef JOY_TX_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
